// File: rtl/gxsim_reg_pkg.sv
// Shared opcodes, command sizes and FSM state encoding for the host-register initiator.
package gxsim_reg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int CMD_ADDR_BYTES = 4;
    localparam int CMD_DATA_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        READ,
        RSP,
        ERR
    } state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/gxsim_byte_serializer.sv
// Loads a 32-bit word and emits it MSB-first as four bytes on a valid/ready stream;
// done pulses combinationally on the handshake of the fourth byte.
module gxsim_byte_serializer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] load_data,
    output logic [7:0]  tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        done
);

    logic [31:0] sreg;
    logic [1:0]  cnt;

    assign tdata = sreg[31:24];
    assign done  = tvalid && tready && (cnt == 2'd3);

    // Shifting in zeros leaves tdata at 0 once the word has drained.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sreg   <= '0;
            cnt    <= '0;
            tvalid <= 1'b0;
        end else if (load) begin
            sreg   <= load_data;
            cnt    <= '0;
            tvalid <= 1'b1;
        end else if (tvalid && tready) begin
            sreg <= {sreg[23:0], 8'h00};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3)
                tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/gxsim_host_reg_initiator.sv
// Byte-stream read/write command parser driving the simulated host-register port.
// Define GXSIM_ERR_RESP_EN to answer an illegal opcode with a single ERR_BYTE response.
module gxsim_host_reg_initiator
    import gxsim_reg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    output logic [7:0]  m_rsp_tdata,
    output logic        m_rsp_tvalid,
    input  logic        m_rsp_tready,
    output logic [31:0] address,
    output logic [31:0] wdata,
    output logic        write_strobe,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam logic [1:0] LAST_ADDR = 2'(CMD_ADDR_BYTES - 1);
    localparam logic [1:0] LAST_DATA = 2'(CMD_DATA_BYTES - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] stage;
    logic        is_wr;
    logic        cmd_hs;
    logic [31:0] stage_next;
    logic        ser_load;
    logic        ser_tvalid;
    logic        ser_done;
    logic [7:0]  ser_tdata;

    assign s_cmd_tready = resetn && (state == IDLE || state == ADDR || state == WDATA);
    assign cmd_hs       = s_cmd_tvalid && s_cmd_tready;
    assign stage_next   = {stage[23:0], s_cmd_tdata};
    assign busy         = (state != IDLE);
    assign ser_load     = (state == READ);

    // address/wdata only update on the final byte so the port never sees a partial value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            stage        <= '0;
            is_wr        <= 1'b0;
            address      <= '0;
            wdata        <= '0;
            write_strobe <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            case (state)
                IDLE: if (cmd_hs) begin
                    cnt   <= '0;
                    is_wr <= (s_cmd_tdata == OP_WRITE);
                    state <= is_legal_op(s_cmd_tdata) ? ADDR : ERR;
                end
                ADDR: if (cmd_hs) begin
                    stage <= stage_next;
                    if (cnt == LAST_ADDR) begin
                        address <= stage_next;
                        cnt     <= '0;
                        state   <= is_wr ? WDATA : READ;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                WDATA: if (cmd_hs) begin
                    stage <= stage_next;
                    if (cnt == LAST_DATA) begin
                        wdata        <= stage_next;
                        cnt          <= '0;
                        write_strobe <= 1'b1;
                        state        <= WRITE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                WRITE: state <= IDLE;
                READ:  state <= RSP;
                RSP:   if (ser_done) state <= IDLE;
`ifdef GXSIM_ERR_RESP_EN
                ERR:   if (m_rsp_tready) state <= IDLE;
`else
                ERR:   state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    gxsim_byte_serializer u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .load      (ser_load),
        .load_data (rdata),
        .tdata     (ser_tdata),
        .tvalid    (ser_tvalid),
        .tready    (m_rsp_tready),
        .done      (ser_done)
    );

`ifdef GXSIM_ERR_RESP_EN
    assign m_rsp_tvalid = ser_tvalid || (state == ERR);
    assign m_rsp_tdata  = (state == ERR) ? ERR_BYTE : ser_tdata;
`else
    assign m_rsp_tvalid = ser_tvalid;
    assign m_rsp_tdata  = ser_tdata;
`endif

endmodule
